phy_free_list: RTL

Physical-register free list for the 2-wide rename/dispatch stage that feeds the reorder buffer. Hands out up to two free physical registers per cycle for new destination mappings and reclaims the old physical register of each retiring instruction from the ROB commit port. Keeps a second bitmap of architecturally committed mappings, so a flush restores the free list in one cycle.

---
 rtl/phy_free_list_if.sv | 32 +++
 rtl/phy_free_list.sv | 129 ++++++++++++
 2 files changed

// File: rtl/phy_free_list_if.sv
// Dispatch/commit bus of the physical-register free list.
// master: rename/dispatch and ROB commit side. slave: the free list.
interface phy_free_list_if #(
  parameter int PHY_WIDTH = 6
);
  logic                 flush;
  logic [1:0]           alloc_req;
  logic                 alloc_ready;
  logic [PHY_WIDTH-1:0] alloc_phy_0;
  logic [PHY_WIDTH-1:0] alloc_phy_1;
  logic                 retire_pr_valid;
  logic [4:0]           rd_arch_commit;
  logic [PHY_WIDTH-1:0] rd_phy_old_commit;
  logic [PHY_WIDTH-1:0] rd_phy_new_commit;
  logic [PHY_WIDTH:0]   free_count;
  logic                 free_empty;
  logic                 free_almost_empty;

  modport master (
    output flush, alloc_req, retire_pr_valid, rd_arch_commit,
           rd_phy_old_commit, rd_phy_new_commit,
    input  alloc_ready, alloc_phy_0, alloc_phy_1, free_count,
           free_empty, free_almost_empty
  );

  modport slave (
    input  flush, alloc_req, retire_pr_valid, rd_arch_commit,
           rd_phy_old_commit, rd_phy_new_commit,
    output alloc_ready, alloc_phy_0, alloc_phy_1, free_count,
           free_empty, free_almost_empty
  );
endinterface

// File: rtl/phy_free_list.sv
// Physical-register free list for a 2-wide rename stage.
// Hands out up to two free PRs per cycle, reclaims the old PR of each retiring
// instruction and keeps a committed-mapping bitmap for one-cycle flush recovery.
// Optional: define PHY_FREELIST_CHECK_EN to compile in simulation-only
// consistency assertions; the synthesizable logic is unchanged either way.
module phy_free_list #(
  parameter int NUM_PHY_REG  = 64,
  parameter int PHY_WIDTH    = 6,
  parameter int NUM_ARCH_REG = 32
) (
  input logic             clk,
  input logic             rst,
  phy_free_list_if.slave  bus
);

  localparam logic [NUM_PHY_REG-1:0] ARCH_INIT =
    {{(NUM_PHY_REG-NUM_ARCH_REG){1'b0}}, {NUM_ARCH_REG{1'b1}}};
  localparam logic [PHY_WIDTH:0] COUNT_INIT =
    (PHY_WIDTH+1)'(NUM_PHY_REG - NUM_ARCH_REG);

  logic [NUM_PHY_REG-1:0] spec_free, spec_free_next;
  logic [NUM_PHY_REG-1:0] arch_used, arch_used_next;
  logic [PHY_WIDTH:0]     free_count, free_count_next;

  logic [PHY_WIDTH-1:0]   pick0, pick1;
  logic                   found0, found1;
  logic [1:0]             req_cnt, alloc_cnt;
  logic                   alloc_do, retire_ok, freed;

  // Lowest two set bits of spec_free (0 when fewer exist).
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves it unassigned, which would otherwise infer a latch.
    pick0  = '0;
    pick1  = '0;
    found0 = 1'b0;
    found1 = 1'b0;
    for (int i = 0; i < NUM_PHY_REG; i++) begin
      if (spec_free[i]) begin
        if (!found0) begin
          pick0  = PHY_WIDTH'(i);
          found0 = 1'b1;
        end else if (!found1) begin
          pick1  = PHY_WIDTH'(i);
          found1 = 1'b1;
        end
      end
    end
  end

  assign req_cnt       = {1'b0, bus.alloc_req[0]} + {1'b0, bus.alloc_req[1]};
  assign bus.alloc_ready = free_count >= (PHY_WIDTH+1)'(req_cnt);
  // A lone slot-1 request takes the lowest free PR, like a lone slot-0 one.
  assign bus.alloc_phy_0 = bus.alloc_req[0] ? pick0 : '0;
  assign bus.alloc_phy_1 = bus.alloc_req[1] ? (bus.alloc_req[0] ? pick1 : pick0) : '0;
  assign bus.free_count        = free_count;
  assign bus.free_empty        = (free_count == '0);
  assign bus.free_almost_empty = (free_count < (PHY_WIDTH+1)'(2));

  assign alloc_do  = bus.alloc_ready && !bus.flush && (bus.alloc_req != 2'b00);
  assign alloc_cnt = alloc_do ? req_cnt : 2'd0;
  assign retire_ok = bus.retire_pr_valid && (bus.rd_arch_commit != 5'd0);
  // PR0 is hard-wired to x0 and never returns to the free pool.
  assign freed     = retire_ok && (bus.rd_phy_old_commit != '0);

  // Next-state of both bitmaps and the free counter.
  always_comb begin
    arch_used_next  = arch_used;
    spec_free_next  = spec_free;
    free_count_next = free_count;
    if (retire_ok) begin
      arch_used_next[bus.rd_phy_old_commit] = 1'b0;
      // Applied after the clear so old==new leaves the mapping committed.
      arch_used_next[bus.rd_phy_new_commit] = 1'b1;
      if (freed) spec_free_next[bus.rd_phy_old_commit] = 1'b1;
    end
    if (bus.flush) begin
      // Everything not committed is free again; in-flight grants are dropped.
      spec_free_next    = ~arch_used_next;
      spec_free_next[0] = 1'b0;
      free_count_next   = COUNT_INIT;
    end else begin
      if (alloc_do && bus.alloc_req[0]) spec_free_next[bus.alloc_phy_0] = 1'b0;
      if (alloc_do && bus.alloc_req[1]) spec_free_next[bus.alloc_phy_1] = 1'b0;
      free_count_next = free_count + (PHY_WIDTH+1)'(freed)
                                   - (PHY_WIDTH+1)'(alloc_cnt);
    end
  end

  // State registers; reset restores the identity mapping of x0..x31.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      arch_used  <= ARCH_INIT;
      spec_free  <= ~ARCH_INIT;
      free_count <= COUNT_INIT;
    end else begin
      arch_used  <= arch_used_next;
      spec_free  <= spec_free_next;
      free_count <= free_count_next;
    end
  end

`ifdef PHY_FREELIST_CHECK_EN
  // Simulation-only consistency checks on grants, reclaims and bookkeeping.
  always @(posedge clk) begin
    if (!rst) begin
      if (alloc_do && bus.alloc_req[0])
        assert (spec_free[bus.alloc_phy_0])
          else $error("phy_free_list: granted PR %0d is not free", bus.alloc_phy_0);
      if (alloc_do && bus.alloc_req[1])
        assert (spec_free[bus.alloc_phy_1])
          else $error("phy_free_list: granted PR %0d is not free", bus.alloc_phy_1);
      if (freed)
        assert (!spec_free[bus.rd_phy_old_commit])
          else $error("phy_free_list: reclaimed PR %0d already free", bus.rd_phy_old_commit);
      assert ($countones(arch_used) == NUM_ARCH_REG)
        else $error("phy_free_list: arch_used popcount %0d", $countones(arch_used));
      assert (int'(free_count) == $countones(spec_free))
        else $error("phy_free_list: free_count %0d vs popcount %0d",
                    free_count, $countones(spec_free));
    end
  end
`else
  // Consistency checks not compiled in.
`endif

endmodule
